// File: rtl/imm_ext_unit.sv
// Registered immediate extender with a 2-entry elastic output buffer (main + skid).
// Extension happens on the input side; only the extended OUT_W value is stored.
module imm_ext_unit #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16,
   parameter int SHAMT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [OUT_W-1:0] main_q, main_d;
   logic [OUT_W-1:0] skid_q, skid_d;
   logic [OUT_W-1:0] ext_val;
   logic             acc;
   logic             pop;

   // Handshake flags come straight from the state flops, so out_ready never reaches in_ready.
   assign in_ready  = (state_q != S_FULL);
   assign out_valid = (state_q != S_EMPTY);
   assign out_data  = main_q;
   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // A size cast of a signed operand sign-extends; this stays legal even when OUT_W == IN_W.
   always_comb begin
      ext_val = '0;
      case (in_mode)
         2'd0:    ext_val = OUT_W'(in_data);
         2'd1:    ext_val = OUT_W'($signed(in_data));
         2'd2:    ext_val = OUT_W'($signed(in_data)) << SHAMT;
         default: ext_val = OUT_W'(in_data) << (OUT_W - IN_W);
      endcase
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (acc) begin
               state_d = S_ONE;
               main_d  = ext_val;
            end
         end
         S_ONE: begin
            if (acc && pop) begin
               main_d = ext_val;
            end else if (acc) begin
               state_d = S_FULL;
               skid_d  = ext_val;
            end else if (pop) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (pop) begin
               state_d = S_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Self-checking bench for imm_ext_unit: directed scenarios plus a randomized
// stall run scored against a queue-based reference model.
module tb_imm_ext_unit;

   localparam int IN_W  = 8;
   localparam int OUT_W = 16;
   localparam int SHAMT = 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;

   int checks;
   int failures;

   // Handshake as observed just before the most recent rising edge.
   logic             s_acc;
   logic             s_pop;
   logic             s_valid;
   logic             s_ready;
   logic [OUT_W-1:0] s_data;

   imm_ext_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference extension from the arithmetic meaning of each mode, reduced modulo 2**OUT_W.
   function automatic logic [OUT_W-1:0] model_ext(input int d, input int m);
      longint s;
      longint r;
      longint modulus;
      modulus = longint'(1) << OUT_W;
      s = (d >= (1 << (IN_W - 1))) ? longint'(d) - (longint'(1) << IN_W) : longint'(d);
      case (m)
         0:       r = d;
         1:       r = s;
         2:       r = s * (longint'(1) << SHAMT);
         default: r = longint'(d) * (longint'(1) << (OUT_W - IN_W));
      endcase
      r = ((r % modulus) + modulus) % modulus;
      return r[OUT_W-1:0];
   endfunction

   // Sample the handshake at the falling edge, then advance past the rising edge.
   task automatic step();
      @(negedge clk);
      s_valid = out_valid;
      s_ready = out_ready;
      s_data  = out_data;
      s_acc   = in_valid && in_ready;
      s_pop   = out_valid && out_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 2'd0;
      out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b want=0", out_valid);
      end
      checks++;
      if (out_data !== 16'h0000) begin
         failures++;
         $display("FAIL reset_out_data got=%h want=0000", out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_modes();
      logic [7:0]  d[5];
      logic [1:0]  m[5];
      logic [15:0] e[5];
      d = '{8'h80, 8'h80, 8'h7F, 8'hFE, 8'hA5};
      m = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
      e = '{16'h0080, 16'hFF80, 16'h007F, 16'hFFFC, 16'hA500};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = d[i];
         in_mode  = m[i];
         step();
         checks++;
         if (!s_acc || out_valid !== 1'b1 || out_data !== e[i]) begin
            failures++;
            $display("FAIL modes_item%0d acc=%b valid=%b got=%h want=%h", i, s_acc, out_valid, out_data, e[i]);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (!s_pop || s_data !== e[4] || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL modes_drain pop=%b data=%h valid=%b want pop=1 data=%h valid=0", s_pop, s_data, out_valid, e[4]);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] got[$];
      logic [7:0]  vals[3];
      int          k;
      int          saw_refill;
      vals = '{8'h01, 8'h02, 8'h03};
      out_ready = 1'b0;
      in_mode   = 2'd0;
      in_valid  = 1'b1;
      in_data   = vals[0];
      k = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (s_acc) begin
            k++;
            if (k < 3) in_data = vals[k];
         end
      end
      checks++;
      if (k !== 2 || in_ready !== 1'b0 || out_data !== 16'h0001) begin
         failures++;
         $display("FAIL bp_fill accepted=%0d in_ready=%b head=%h want accepted=2 in_ready=0 head=0001", k, in_ready, out_data);
      end
      out_ready  = 1'b1;
      saw_refill = 0;
      for (int c = 0; c < 20 && got.size() < 3; c++) begin
         step();
         if (s_pop) begin
            got.push_back(s_data);
            if (got.size() == 1) saw_refill = (in_ready === 1'b1) ? 1 : 0;
         end
         if (s_acc) begin
            k++;
            if (k < 3) in_data = vals[k];
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (saw_refill != 1) begin
         failures++;
         $display("FAIL bp_in_ready_rise got=%0d want=1", saw_refill);
      end
      checks++;
      if (got.size() != 3) begin
         failures++;
         $display("FAIL bp_count got=%0d want=3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== model_ext(int'(vals[i]), 0)) begin
               failures++;
               $display("FAIL bp_order idx=%0d got=%h want=%h", i, got[i], model_ext(int'(vals[i]), 0));
            end
         end
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || s_pop) begin
         failures++;
         $display("FAIL bp_no_dup valid=%b pop=%b want 0/0", out_valid, s_pop);
      end
   endtask

   task automatic test_streaming();
      int ready_drops;
      int bad_out;
      ready_drops = 0;
      bad_out     = 0;
      out_ready   = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         in_valid = (i < 16);
         in_data  = IN_W'(i);
         in_mode  = 2'd1;
         step();
         if (i < 16 && !s_acc) ready_drops++;
         if (i > 0 && (!s_pop || s_data !== model_ext(i - 1, 1))) bad_out++;
      end
      in_valid = 1'b0;
      checks++;
      if (ready_drops != 0) begin
         failures++;
         $display("FAIL stream_in_ready drops=%0d want=0", ready_drops);
      end
      checks++;
      if (bad_out != 0) begin
         failures++;
         $display("FAIL stream_out bad_cycles=%0d want=0", bad_out);
      end
   endtask

   task automatic test_random();
      logic [15:0] exp_q[$];
      logic [15:0] held;
      logic        prev_hold;
      logic [15:0] want;
      int          pops;
      prev_hold = 1'b0;
      held      = '0;
      pops      = 0;
      for (int c = 0; c < 1000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = IN_W'($urandom);
         in_mode   = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 2) != 0);
         step();
         if (prev_hold) begin
            checks++;
            if (s_valid !== 1'b1 || s_data !== held) begin
               failures++;
               $display("FAIL rand_stable cycle=%0d valid=%b got=%h want=%h", c, s_valid, s_data, held);
            end
         end
         if (s_pop) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rand_spurious cycle=%0d got=%h want=none", c, s_data);
            end else begin
               want = exp_q.pop_front();
               if (s_data !== want) begin
                  failures++;
                  $display("FAIL rand_data cycle=%0d got=%h want=%h", c, s_data, want);
               end
            end
         end
         if (s_acc) exp_q.push_back(model_ext(int'(in_data), int'(in_mode)));
         prev_hold = s_valid && !s_ready;
         held      = s_data;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         if (s_pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rand_drain_spurious got=%h want=none", s_data);
            end else begin
               want = exp_q.pop_front();
               if (s_data !== want) begin
                  failures++;
                  $display("FAIL rand_drain_data got=%h want=%h", s_data, want);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || out_valid !== 1'b0 || pops == 0) begin
         failures++;
         $display("FAIL rand_loss left=%0d valid=%b pops=%0d want left=0 valid=0 pops>0", exp_q.size(), out_valid, pops);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] got[$];
      out_ready = 1'b0;
      in_mode   = 2'd0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      step();
      in_data = 8'h22;
      step();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_full in_ready=%b valid=%b want 0/1", in_ready, out_valid);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_clear valid=%b data=%h in_ready=%b want 0/0000/1", out_valid, out_data, in_ready);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h33;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (s_pop) got.push_back(s_data);
      end
      checks++;
      if (got.size() != 1 || got[0] !== 16'h0033) begin
         failures++;
         $display("FAIL rstmid_after count=%0d first=%h want count=1 first=0033", got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
      end
   endtask

   task automatic test_reset_dominance();
      out_ready = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_mode   = 2'd0;
      in_data   = 8'h44;
      step();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
         failures++;
         $display("FAIL rstdom_accept valid=%b data=%h want 0/0000", out_valid, out_data);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstdom_later valid=%b want=0", out_valid);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_modes();
      test_backpressure();
      test_streaming();
      test_random();
      test_reset_mid();
      test_reset_dominance();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_ext_unit.md
# imm_ext_unit

Parametrised, registered immediate-extension unit with a valid/ready handshake on both sides. It is the successor to the fixed 1-to-8-bit sign extender. It adds configurable input and output widths, four run-time extension modes and a 2-entry elastic output buffer. It sits between instruction decode and the execute-stage operand mux, so decode stalls and operand-mux backpressure are decoupled without losing or duplicating immediates.

## Interface
Parameters:
- IN_W, 8, input immediate width (≥1)
- OUT_W, 16, output operand width; must satisfy OUT_W ≥ IN_W + SHAMT
- SHAMT, 1, left-shift amount applied in mode 2 (branch-offset scaling)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  producer has an immediate
- in_ready  output  1  unit can accept
- in_data  input  IN_W  raw immediate
- in_mode  input  2  0 zero-ext, 1 sign-ext, 2 sign-ext then << SHAMT, 3 upper-place
- out_valid  output  1  out_data holds an extended value
- out_ready  input  1  consumer takes out_data
- out_data  output  OUT_W  extended immediate

## Operation
- Accept occurs when in_valid && in_ready at a rising edge. Pop occurs when out_valid && out_ready at a rising edge.
- Extension is combinational on the input side, and only the extended OUT_W value is stored:
  - mode 0: {(OUT_W-IN_W){0}, in_data}
  - mode 1: {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}
  - mode 2: sign-extend to OUT_W, then logical shift left by SHAMT with zero fill; the width rule guarantees no significant bits are lost
  - mode 3: {in_data, (OUT_W-IN_W){0}}
- Storage is a main register (drives out_data) plus a skid register. State is encoded as EMPTY, ONE or FULL:
  - EMPTY: accept → ONE, main ← ext(in).
  - ONE: accept && pop → ONE, main ← ext(in). Accept && !pop → FULL, skid ← ext(in). Pop && !accept → EMPTY. Otherwise hold.
  - FULL: no accept is possible. Pop → ONE, main ← skid. Otherwise hold.
- out_valid = (state != EMPTY). in_ready = (state != FULL). Both decode directly from state flops, so there is no combinational path from out_ready to in_ready.
- Ordering is strict FIFO. Every accepted immediate appears on out_data exactly once.
- out_data holds its value while out_valid && !out_ready. In EMPTY it holds the last popped value, and consumers must ignore it.
- Reset: on a rising edge with rst_n = 0:
  - state ← EMPTY
  - main and skid ← 0
  - out_valid = 0, out_data = 0, in_ready = 1 after that edge
  - in_valid is ignored on any edge where rst_n = 0
  - reset in any state, including FULL mid-backpressure, discards all stored data

## Timing
- Latency is 1 cycle. A value accepted at edge N is on out_data with out_valid = 1 after edge N, so it can be popped at edge N+1.
- Throughput is 1 immediate per cycle with out_ready held high (steady ONE state, simultaneous accept and pop).
- Under backpressure, 2 values are buffered. in_ready falls after the edge that fills skid and rises after the first pop from FULL.
- After a pop from FULL, the accept of the next input is possible on the following edge (one bubble cycle on the input side only).
- in_mode and in_data are sampled only on the accept edge. Mode changes between items take effect per item with no pipeline flush.

## Test plan
Parameters for all scenarios: IN_W=8, OUT_W=16, SHAMT=1.

- **Modes:** out_ready=1; send 0x80/m0, 0x80/m1, 0x7F/m1, 0xFE/m2, 0xA5/m3 back-to-back → out_data 0x0080, 0xFF80, 0x007F, 0xFFFC, 0xA500 on consecutive cycles, each 1 cycle after accept.
- **Backpressure:** out_ready=0; offer 0x01, 0x02, 0x03 (m0) continuously →
  - 0x01 and 0x02 are accepted, then in_ready=0 and 0x03 is held.
  - With out_ready=1, the bench sees 0x0001, 0x0002, 0x0003 in order with no duplicates; in_ready re-rises after the first pop.
- **Streaming:** out_ready=1; send 0x00..0x0F (m1) on 16 consecutive cycles →
  - in_ready stays 1 throughout.
  - Output is 0x0000..0x000F on 16 consecutive cycles.
- **Random stall:** random in_valid and out_ready for 1000 cycles against a reference FIFO model → no loss, no duplicates, order preserved, out_data stable whenever out_valid && !out_ready.
- **Reset mid-operation:** reach FULL with 0x11 and 0x22, then pulse rst_n=0 for one edge →
  - Next cycle: out_valid=0, out_data=0x0000, in_ready=1.
  - Then send 0x33/m0 → 0x0033 is the only output; 0x11 and 0x22 never appear.
- **Reset dominance:** assert in_valid=1 with 0x44 during the rst_n=0 edge → the value is not accepted and out_valid remains 0 after reset.
